// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory responder and the datapath.
package mem_pkg;

   localparam int unsigned MEM_ADDR_WIDTH = 10;
   localparam int unsigned MEM_DATA_WIDTH = 32;
   localparam logic [31:0] MEM_ERR_DATA   = 32'h0;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // Where the held rsp_data value comes from after the last completed load.
   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_ERR  = 2'd2
   } rsp_src_e;

   // A word address is valid only when every bit above the implemented ones is zero.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
      return (addr >> aw) == 32'd0;
   endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous word RAM: write-enable, read-enable, registered read, no reset.
module data_ram
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read data only changes on an enabled read, so it also acts as the held load result.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the datapath load/store port.
//
//   state | meaning
//   IDLE  | ready for a request; also the cycle in which rsp_valid pulses
//   BUSY  | request latched; counting down wait states, access when count is zero
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH  = MEM_ADDR_WIDTH,
   parameter int unsigned          DATA_WIDTH  = MEM_DATA_WIDTH,
   parameter int unsigned          WAIT_CYCLES = 1,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(MEM_ERR_DATA)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic                  rsp_we,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [31:0]            addr_q, addr_d;
   logic                   we_q, we_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_we_q, rsp_we_d;
   logic                   rsp_err_q, rsp_err_d;
   rsp_src_e               src_q, src_d;

   logic                   access;
   logic                   in_range;
   logic                   ram_we;
   logic                   ram_re;
   logic [DATA_WIDTH-1:0]  ram_rdata;

   assign in_range = addr_in_range(addr_q, ADDR_WIDTH);

   // Reset must also block the RAM, so a store committing on a reset edge is dropped.
   assign ram_we = access &  we_q & in_range & ~rst;
   assign ram_re = access & ~we_q & in_range & ~rst;

   data_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_data_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (addr_q[ADDR_WIDTH-1:0]),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   // Next-state, request latching, wait countdown and response generation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      src_d       = src_q;
      rsp_we_d    = rsp_we_q;
      access      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               we_d    = req_we;
               wdata_d = req_wdata;
               cnt_d   = WAIT_INIT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (access) begin
         rsp_we_d = we_q;
         if (!we_q) begin
            src_d = in_range ? SRC_RAM : SRC_ERR;
         end
      end
      rsp_valid_d = access;
      rsp_err_d   = access & ~in_range;
   end

   // State and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 32'd0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         src_q       <= SRC_ZERO;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_err_q   <= rsp_err_d;
         src_q       <= src_d;
      end
   end

   // Held load result: zero after reset, RAM read register, or the error word.
   always_comb begin
      rsp_data = '0;
      unique case (src_q)
         SRC_RAM: rsp_data = ram_rdata;
         SRC_ERR: rsp_data = ERR_DATA;
         default: rsp_data = '0;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 has WAIT_CYCLES=0, instance 1 has WAIT_CYCLES=1.
module tb_data_mem_responder;

   localparam logic [31:0] ERR_W = 32'h0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, req_valid, req_we, req_ready, rsp_valid, rsp_we, rsp_err;
   logic [1:0][31:0] req_addr, req_wdata, rsp_data;

   data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0), .ERR_DATA(ERR_W)) u_dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
      .rsp_valid(rsp_valid[0]), .rsp_we(rsp_we[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]));

   data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(1), .ERR_DATA(ERR_W)) u_dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
      .rsp_valid(rsp_valid[1]), .rsp_we(rsp_we[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: word memory per instance plus the last load result.
   logic [31:0] m_mem  [2][1024];
   logic [31:0] m_last [2];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] ed;
      logic        ee;
      bit          scr;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic void model_apply(input int d, input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata,
                                       output logic [31:0] ed, output logic ee);
      logic in_r;
      in_r = (addr >> 10) == 32'd0;
      ee   = ~in_r;
      if (we) begin
         if (in_r) m_mem[d][addr[9:0]] = wdata;
      end else begin
         m_last[d] = in_r ? m_mem[d][addr[9:0]] : ERR_W;
      end
      ed = m_last[d];
   endfunction

   // One request; latency is counted in falling edges after the accepting edge.
   task automatic do_req(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] ed, input logic ee, input bit scr, input string nm);
      int lat;
      bit got;
      @(negedge clk);
      chk({nm, " ready_idle"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      @(negedge clk);
      if (!scr) req_valid[d] = 1'b0;
      lat = 1;
      got = 1'b0;
      while (lat <= 40 && !got) begin
         if (rsp_valid[d]) begin
            got = 1'b1;
         end else begin
            chk({nm, " ready_busy"}, 32'(req_ready[d]), 32'd0);
            if (scr) begin
               req_addr[d]  = $urandom;
               req_wdata[d] = $urandom;
               req_we[d]    = ~req_we[d];
            end
            @(negedge clk);
            lat++;
         end
      end
      req_valid[d] = 1'b0;
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: no rsp_valid within 40 cycles", nm);
         return;
      end
      chk({nm, " latency"}, 32'(lat), 32'(d + 2));
      chk({nm, " rsp_we"}, 32'(rsp_we[d]), 32'(we));
      chk({nm, " rsp_err"}, 32'(rsp_err[d]), 32'(ee));
      chk({nm, " rsp_data"}, rsp_data[d], ed);
      chk({nm, " ready_rsp"}, 32'(req_ready[d]), 32'd1);
      @(negedge clk);
      chk({nm, " pulse_end"}, 32'(rsp_valid[d]), 32'd0);
   endtask

   task automatic model_req(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit scr, input string nm);
      logic [31:0] ed;
      logic        ee;
      model_apply(d, we, addr, wdata, ed, ee);
      do_req(d, we, addr, wdata, ed, ee, scr, nm);
   endtask

   initial begin
      logic [31:0] ed, a;
      logic        ee;
      int          r;

      rst = 2'b11; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      m_last[0] = 32'd0; m_last[1] = 32'd0;
      repeat (3) @(negedge clk);
      rst = 2'b00;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset ready", 32'(req_ready[d]), 32'd1);
         chk("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
         chk("reset rsp_we", 32'(rsp_we[d]), 32'd0);
         chk("reset rsp_err", 32'(rsp_err[d]), 32'd0);
         chk("reset rsp_data", rsp_data[d], 32'd0);
      end

      // Directed table on the WAIT_CYCLES=1 instance.
      tbl[0] = '{1'b1, 32'h0000_0005, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 32'h0000_0005, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 32'h0000_0000, 32'h0000_0007, 32'hCAFE_F00D, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0007, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 32'h0000_0400, 32'h0,         ERR_W,         1'b1, 1'b0};
      tbl[6] = '{1'b1, 32'h0000_03FF, 32'hFFFF_FFFF, ERR_W,         1'b0, 1'b0};
      tbl[7] = '{1'b0, 32'h0000_03FF, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 32'h8000_0005, 32'h0,         ERR_W,         1'b1, 1'b0};
      tbl[9] = '{1'b0, 32'h0000_0005, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         model_apply(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, ed, ee);
         do_req(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ed, tbl[i].ee, tbl[i].scr,
                $sformatf("tbl%0d", i));
      end

      // WAIT_CYCLES=0, req_valid held high across two back-to-back loads.
      model_req(0, 1'b1, 32'd5, 32'hCAFE_F00D, 1'b0, "b2b pre5");
      model_req(0, 1'b1, 32'd6, 32'h0000_0001, 1'b0, "b2b pre6");
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'd5;
      @(negedge clk);
      chk("b2b ready_busy1", 32'(req_ready[0]), 32'd0);
      chk("b2b no_rsp1", 32'(rsp_valid[0]), 32'd0);
      req_addr[0] = 32'd6;
      @(negedge clk);
      chk("b2b rsp1_valid", 32'(rsp_valid[0]), 32'd1);
      chk("b2b rsp1_data", rsp_data[0], 32'hCAFE_F00D);
      chk("b2b rsp1_ready", 32'(req_ready[0]), 32'd1);
      @(negedge clk);
      chk("b2b ready_busy2", 32'(req_ready[0]), 32'd0);
      chk("b2b no_rsp2", 32'(rsp_valid[0]), 32'd0);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("b2b rsp2_valid", 32'(rsp_valid[0]), 32'd1);
      chk("b2b rsp2_data", rsp_data[0], 32'h0000_0001);
      chk("b2b rsp2_err", 32'(rsp_err[0]), 32'd0);
      m_last[0] = 32'h0000_0001;
      @(negedge clk);
      chk("b2b pulse_end", 32'(rsp_valid[0]), 32'd0);

      // Reset landing on the commit edge of a store (WAIT_CYCLES=1).
      model_req(1, 1'b1, 32'd9, 32'h0, 1'b0, "rst pre9");
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'd9; req_wdata[1] = 32'h1234_5678;
      @(negedge clk);
      req_valid[1] = 1'b0;
      chk("rst ready_busy", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      m_last[1] = 32'd0;
      chk("rst no_rsp", 32'(rsp_valid[1]), 32'd0);
      chk("rst ready", 32'(req_ready[1]), 32'd1);
      chk("rst rsp_data", rsp_data[1], 32'd0);
      @(negedge clk);
      chk("rst still_no_rsp", 32'(rsp_valid[1]), 32'd0);
      do_req(1, 1'b0, 32'd9, 32'h0, 32'h0, 1'b0, 1'b0, "rst load9");
      m_last[1] = 32'd0;

      // Randomized traffic against the model on both instances.
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 16; k++) begin
            model_req(d, 1'b1, 32'(k), $urandom, 1'b0, "fill lo");
            model_req(d, 1'b1, 32'h3F0 + 32'(k), $urandom, 1'b0, "fill hi");
         end
         for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, 15));
            else if (r < 8) a = 32'h3F0 + 32'($urandom_range(0, 15));
            else            a = 32'h400 + ($urandom & 32'h7FFF_FC00);
            model_req(d, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
                      $sformatf("rnd d%0d n%0d", d, n));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
